// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// RV32I lane steering for stores and lane extraction/extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data,
    output logic        misalign
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic zext);
        logic signed [7:0]  b_s;
        logic signed [31:0] b_x;
        b_s = b;
        b_x = b_s;
        return zext ? {24'h0, b} : b_x;
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic zext);
        logic signed [15:0] h_s;
        logic signed [31:0] h_x;
        h_s = h;
        h_x = h_s;
        return zext ? {16'h0, h} : h_x;
    endfunction

    // Half and word accesses ignore the low address bits, which aligns them down.
    always_comb begin
        byte_en  = 4'b1111;
        wr_word  = wdata;
        ld_data  = ram_word;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << addr_lo;
                wr_word = {4{wdata[7:0]}};
                ld_data = ext_byte(ram_word[{addr_lo, 3'b000} +: 8], is_unsigned);
            end
            SZ_HALF: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_word  = {2{wdata[15:0]}};
                ld_data  = ext_half(addr_lo[1] ? ram_word[31:16] : ram_word[15:0], is_unsigned);
                misalign = addr_lo[0];
            end
            default: begin
                byte_en  = 4'b1111;
                wr_word  = wdata;
                ld_data  = ram_word;
                misalign = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory responder for the core load/store port.
// Optional DMEM_MISALIGN_ERR_EN: misaligned or reserved-size accesses raise rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int B_WIDTH     = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [B_WIDTH-1:0] req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;

    logic [31:0] mem [DEPTH_WORDS];

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    size_e                 size_q, size_d;
    logic                  uns_q, uns_d;

    logic          from_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata;
    size_e         a_size;
    logic          a_uns;
    logic [IDX_W-1:0] idx;
    logic [3:0]    byte_en;
    logic [31:0]   wr_word;
    logic [31:0]   ld_data;
    logic          misalign;
    logic          acc_err;
    logic          acc_fire;
    logic [31:0]   acc_rdata;

    logic unused_addr;
    assign unused_addr = ^req_addr[B_WIDTH-1:AW];

    // With zero wait states the access happens on the accept edge, straight from the request.
    assign from_req = (state_q == ST_IDLE);
    assign a_we     = from_req ? req_we                   : we_q;
    assign a_addr   = from_req ? req_addr[AW-1:0]         : addr_q;
    assign a_wdata  = from_req ? req_wdata                : wdata_q;
    assign a_size   = from_req ? size_e'(req_size)        : size_q;
    assign a_uns    = from_req ? req_unsigned             : uns_q;
    assign idx      = a_addr[AW-1:2];

    dmem_lane_align u_lane_align (
        .addr_lo     (a_addr[1:0]),
        .size        (a_size),
        .is_unsigned (a_uns),
        .wdata       (a_wdata),
        .ram_word    (mem[idx]),
        .byte_en     (byte_en),
        .wr_word     (wr_word),
        .ld_data     (ld_data),
        .misalign    (misalign)
    );

`ifdef DMEM_MISALIGN_ERR_EN
    assign acc_err = misalign || (a_size == SZ_RSVD);
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign acc_err         = 1'b0;
`endif

    assign acc_fire  = ((state_q == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                       ((state_q == ST_WAIT) && (cnt_q == '0));
    assign acc_rdata = (a_we || acc_err) ? 32'h0 : ld_data;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    if (WAIT_CYCLES == 0) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = acc_rdata;
                        rsp_err_d   = acc_err;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = acc_rdata;
                    rsp_err_d   = acc_err;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
    end

    // Reset on the access edge suppresses the commit of a pending store.
    always_ff @(posedge clk) begin
        if (!rst && acc_fire && a_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's load/store port: accepts byte/half/word load and store requests over a valid/ready handshake.
- Holds a word-organised data RAM and returns a response after a configurable number of wait states.
- Performs RV32I lane steering and load sign/zero extension.
- Sits between TRV32I_core and the data address space as the wait-state-capable data memory.

Parameters:
- B_WIDTH, 32, request address width in bits.
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; must be a power of two.
- WAIT_CYCLES, 1, extra cycles between request accept and memory access; range 0..15.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  B_WIDTH  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extends when 1 (LBU/LHU).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load result, extended; 0 for stores.
- rsp_err  output  1  access error; only set when DMEM_MISALIGN_ERR_EN is defined, otherwise tied 0.

Behaviour:
- Reset values: state IDLE, req_ready 1 (combinational from state), rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0. RAM contents are not reset.
- Reset mid-operation drops the in-flight request. A store still in WAIT is never committed.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/size/unsigned. If WAIT_CYCLES>0, go WAIT and load counter=WAIT_CYCLES-1. If WAIT_CYCLES=0, access and go RESP.
  - WAIT: req_ready=0. When counter=0, perform the access and go RESP; otherwise decrement the counter.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready, then go IDLE. Data must not change while stalled.
- Latency: a handshake in cycle N gives rsp_valid high from cycle N+1+WAIT_CYCLES.
- Throughput: one request per 2+WAIT_CYCLES cycles minimum. There is no overlap and no combinational path from req_* to rsp_*.
- Access point: a store write is committed at the clock edge entering RESP. Load data is sampled from the RAM at the same edge, after any store (none, since there is one request at a time).
- Word index: addr[$clog2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Store lanes:
  - byte: write lane addr[1:0] with wdata[7:0].
  - half: write lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - word: write all four lanes.
  - Lanes not written keep their value.
- Load extraction:
  - byte: the selected lane, sign-extended from bit 7 unless req_unsigned.
  - half: the selected half, sign-extended from bit 15 unless req_unsigned.
  - word: the full word; req_unsigned is ignored.
- req_size=11: treated as a word access when the macro is undefined.
- Misalignment (half with addr[0]=1; word with addr[1:0]!=0) with the macro undefined: the address is aligned down before access.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: a misaligned access or req_size=11 gives rsp_err=1 and rsp_rdata=0. No RAM write occurs. Timing is identical to a normal access.
- Undefined: rsp_err is constant 0, and misaligned accesses are aligned down as above.

Decomposition:
- Package dmem_pkg:
  - size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD).
  - state_e enum (ST_IDLE, ST_WAIT, ST_RESP).
  - WAIT_CNT_W=4 constant.
- One sub-module, dmem_lane_align (combinational). Inputs: addr[1:0], size, unsigned, wdata, RAM word. Outputs: 4-bit byte write enable, steered write word, extended load data, misalign flag.

Test Plan:
- Reset then SW 0xDEADBEEF @0x10, then LW @0x10 (WAIT_CYCLES=1) -> rsp_valid 2 cycles after each accept; rdata 0xDEADBEEF.
- SB 0x80 @0x13, then LB and LBU @0x13 -> 0xFFFFFF80 and 0x00000080; LW @0x10 -> 0x80ADBEEF.
- SH 0x8001 @0x22 over an existing 0x11112222 word, then LH and LHU @0x22 -> 0xFFFF8001 and 0x00008001; LW @0x20 -> 0x80012222.
- Hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rdata stable, req_ready=0, a new req_valid is not accepted.
- Assert rst while in WAIT with a pending SW 0x12345678 @0x30 -> outputs return to reset values next cycle; a later LW @0x30 returns the old value.
- LH @0x11: with DMEM_MISALIGN_ERR_EN -> rsp_err=1, rdata=0; without -> rsp_err=0, data read from 0x10.
